// File: rtl/code_conv_pkg.sv
// Shared definitions for the code converter sweep controller
// and the benches that exercise the converter.
package code_conv_pkg;

    localparam int CODE_W    = 4;
    localparam int BCD_FIRST = 0;
    localparam int BCD_LAST  = 9;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        PRESENT,
        DONE
    } state_e;

endpackage

// File: rtl/settle_timer.sv
// Down-counter that times how long each code sits on the converter input.
// load restarts it at SETTLE-1; zero flags the capture cycle.
module settle_timer #(
    parameter int SETTLE = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic dec,
    output logic zero
);

    localparam int W = $clog2(SETTLE) + 1;
    localparam logic [W-1:0] RELOAD = W'(SETTLE - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = RELOAD;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/code_conv_sweep_ctrl.sv
// Steps the converter input through FIRST_CODE..LAST_CODE and hands each
// settled {code, result} pair downstream over a valid/ready handshake.
module code_conv_sweep_ctrl
    import code_conv_pkg::*;
#(
    parameter int FIRST_CODE = BCD_FIRST,
    parameter int LAST_CODE  = BCD_LAST,
    parameter int SETTLE     = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    output logic [CODE_W-1:0] conv_in,
    input  logic [CODE_W-1:0] conv_o,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [CODE_W-1:0] res_code,
    output logic [CODE_W-1:0] res_data,
    output logic              busy,
    output logic              done
);

    if ((FIRST_CODE < 0) || (FIRST_CODE > LAST_CODE) ||
        (LAST_CODE > (2 ** CODE_W) - 1) || (SETTLE < 1)) begin : g_bad_params
        $fatal(1, "code_conv_sweep_ctrl: illegal FIRST_CODE/LAST_CODE/SETTLE");
    end

    localparam logic [CODE_W-1:0] FIRST = CODE_W'(FIRST_CODE);
    localparam logic [CODE_W-1:0] LAST  = CODE_W'(LAST_CODE);

    state_e            state_q, state_d;
    logic [CODE_W-1:0] conv_q, conv_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic [CODE_W-1:0] data_q, data_d;
    logic              load;
    logic              dec;
    logic              zero;

    settle_timer #(
        .SETTLE(SETTLE)
    ) u_timer (
        .clk (clk),
        .rst (rst),
        .load(load),
        .dec (dec),
        .zero(zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            conv_q  <= '0;
            code_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            conv_q  <= conv_d;
            code_q  <= code_d;
            data_q  <= data_d;
        end
    end

    // abort outranks both start and a pending handshake
    always_comb begin
        state_d = state_q;
        conv_d  = conv_q;
        code_d  = code_q;
        data_d  = data_q;
        load    = 1'b0;
        dec     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    state_d = DRIVE;
                    conv_d  = FIRST;
                    load    = 1'b1;
                end
            end
            DRIVE: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (zero) begin
                    state_d = PRESENT;
                    code_d  = conv_q;
                    data_d  = conv_o;
                end else begin
                    dec = 1'b1;
                end
            end
            PRESENT: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (res_ready) begin
                    if (code_q == LAST) begin
                        state_d = DONE;
                    end else begin
                        state_d = DRIVE;
                        conv_d  = conv_q + 1'b1;
                        load    = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        conv_in   = conv_q;
        res_code  = code_q;
        res_data  = data_q;
        res_valid = (state_q == PRESENT);
        busy      = (state_q == DRIVE) || (state_q == PRESENT);
        done      = (state_q == DONE);
    end

endmodule

// File: tb/tb_code_conv_sweep_ctrl.sv
// Bench for the converter sweep controller: directed vector table,
// model-checked sweeps with stalls/random ready, reset and 15..15 corner.
module tb_code_conv_sweep_ctrl;

    localparam int F0 = 0;
    localparam int L0 = 9;
    localparam int S0 = 2;
    localparam int F1 = 15;
    localparam int L1 = 15;
    localparam int S1 = 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       start0, abort0, ready0;
    logic [3:0] conv_in0, conv_o0, code0, data0;
    logic       valid0, busy0, done0;
    logic       start1, abort1, ready1;
    logic [3:0] conv_in1, conv_o1, code1, data1;
    logic       valid1, busy1, done1;

    logic [3:0] lut [16];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // stand-in for the combinational converter
    assign conv_o0 = lut[conv_in0];
    assign conv_o1 = lut[conv_in1];

    code_conv_sweep_ctrl #(
        .FIRST_CODE(F0),
        .LAST_CODE (L0),
        .SETTLE    (S0)
    ) dut0 (
        .clk      (clk),
        .rst      (rst),
        .start    (start0),
        .abort    (abort0),
        .conv_in  (conv_in0),
        .conv_o   (conv_o0),
        .res_valid(valid0),
        .res_ready(ready0),
        .res_code (code0),
        .res_data (data0),
        .busy     (busy0),
        .done     (done0)
    );

    code_conv_sweep_ctrl #(
        .FIRST_CODE(F1),
        .LAST_CODE (L1),
        .SETTLE    (S1)
    ) dut1 (
        .clk      (clk),
        .rst      (rst),
        .start    (start1),
        .abort    (abort1),
        .conv_in  (conv_in1),
        .conv_o   (conv_o1),
        .res_valid(valid1),
        .res_ready(ready1),
        .res_code (code1),
        .res_data (data1),
        .busy     (busy1),
        .done     (done1)
    );

    typedef struct packed {
        logic       start;
        logic       abort;
        logic       ready;
        logic [3:0] conv;
        logic       valid;
        logic       busy;
        logic       done;
        logic [3:0] code;
    } vec_t;

    vec_t tbl [15];

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [14:0] obs0();
        return {conv_in0, valid0, busy0, done0,
                valid0 ? {code0, data0} : 8'h00};
    endfunction

    // Reference: code i starts at the start edge or at the handshake of
    // code i-1; valid once SETTLE edges have passed since it started.
    task automatic sweep(input int mode);
        int  idx, age, fin, stall, d;
        logic r, ev;
        logic [3:0] ec;
        idx = 0; age = 0; fin = 0; stall = 0; d = -1;
        start0 = 1'b1; abort0 = 1'b0; ready0 = 1'b1;
        step();
        start0 = 1'b0;
        for (int c = 0; c < 600; c++) begin
            ev = (fin == 0) && (age >= S0);
            ec = 4'(F0 + idx);
            check($sformatf("sweep%0d_c%0d", mode, c), 32'(obs0()),
                  32'({ec, ev, fin == 0, fin == 1,
                       ev ? {ec, lut[ec]} : 8'h00}));
            if (fin == 2) break;
            if (mode == 0) begin
                r = 1'b1;
            end else if (mode == 1) begin
                if (ev && ec == 4'd4 && stall < 5) begin
                    r = 1'b0;
                    stall++;
                end else begin
                    r = 1'b1;
                end
            end else begin
                r = ($urandom_range(0, 3) != 0);
            end
            if (fin == 1) begin
                fin = 2;
            end else if (ev && r) begin
                if (idx == L0 - F0) begin
                    fin = 1;
                    d = c + 1;
                end else begin
                    idx++;
                    age = 0;
                end
            end else begin
                age++;
            end
            ready0 = r;
            step();
        end
        check($sformatf("sweep%0d_finished", mode), 32'(fin), 32'd2);
        if (mode == 0) check("done_edge", 32'(d), 32'd30);
        if (mode == 1) check("stall_cycles", 32'(stall), 32'd5);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        lut = '{4'h9, 4'hC, 4'h5, 4'hA, 4'h7, 4'hE, 4'h1, 4'hB,
                4'h6, 4'h2, 4'h3, 4'h8, 4'h0, 4'hD, 4'h4, 4'hF};
        //            st ab rd conv  v  b  d  code
        tbl[0]  = {1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0};
        tbl[1]  = {1'b1, 1'b0, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0, 4'd0};
        tbl[2]  = {1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd0};
        tbl[3]  = {1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 4'd0};
        tbl[4]  = {1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 4'd0};
        tbl[5]  = {1'b0, 1'b0, 1'b1, 4'd1, 1'b0, 1'b1, 1'b0, 4'd0};
        tbl[6]  = {1'b1, 1'b0, 1'b1, 4'd1, 1'b0, 1'b1, 1'b0, 4'd0};
        tbl[7]  = {1'b0, 1'b0, 1'b1, 4'd1, 1'b1, 1'b1, 1'b0, 4'd1};
        tbl[8]  = {1'b0, 1'b1, 1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 4'd1};
        tbl[9]  = {1'b0, 1'b0, 1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 4'd1};
        tbl[10] = {1'b1, 1'b1, 1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 4'd1};
        tbl[11] = {1'b1, 1'b0, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0, 4'd0};
        tbl[12] = {1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0, 4'd0};
        tbl[13] = {1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0};
        tbl[14] = {1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0};

        rst = 1'b1;
        start0 = 1'b0; abort0 = 1'b0; ready0 = 1'b1;
        start1 = 1'b0; abort1 = 1'b0; ready1 = 1'b1;
        step();
        step();
        check("reset0", 32'({conv_in0, valid0, code0, data0, busy0, done0}), 32'd0);
        check("reset1", 32'({conv_in1, valid1, code1, data1, busy1, done1}), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 15; i++) begin
            start0 = tbl[i].start;
            abort0 = tbl[i].abort;
            ready0 = tbl[i].ready;
            step();
            check($sformatf("vec%0d", i), 32'(obs0()),
                  32'({tbl[i].conv, tbl[i].valid, tbl[i].busy, tbl[i].done,
                       tbl[i].valid ? {tbl[i].code, lut[tbl[i].code]} : 8'h00}));
        end
        start0 = 1'b0;
        abort0 = 1'b0;
        ready0 = 1'b1;

        sweep(0);
        sweep(1);

        start0 = 1'b1;
        step();
        start0 = 1'b0;
        step();
        step();
        step();
        rst = 1'b1;
        start0 = 1'b1;
        step();
        check("rst_mid", 32'({conv_in0, valid0, code0, data0, busy0, done0}), 32'd0);
        step();
        check("rst_start", 32'({conv_in0, valid0, code0, data0, busy0, done0}), 32'd0);
        rst = 1'b0;
        start0 = 1'b0;
        step();
        check("post_rst_idle", 32'({conv_in0, valid0, busy0, done0}), 32'd0);
        sweep(0);

        for (int i = 0; i < 16; i++) lut[i] = 4'($urandom);
        sweep(2);
        sweep(2);

        start1 = 1'b1;
        ready1 = 1'b1;
        step();
        start1 = 1'b0;
        check("one_drive", 32'({conv_in1, valid1, busy1, done1}), 32'({4'hF, 3'b010}));
        step();
        check("one_valid", 32'({conv_in1, valid1, busy1, done1, code1, data1}),
              32'({4'hF, 3'b110, 4'hF, lut[15]}));
        step();
        check("one_done", 32'({conv_in1, valid1, busy1, done1}), 32'({4'hF, 3'b001}));
        step();
        check("one_idle", 32'({conv_in1, valid1, busy1, done1}), 32'({4'hF, 3'b000}));
        step();
        check("one_nowrap", 32'({conv_in1, valid1, busy1, done1}), 32'({4'hF, 3'b000}));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
